tb_sim_verdict: RTL and testbench
=================================

Name: tb_sim_verdict

Overview:
- Testbench-side judge stage fed directly by the tohost/cycle/instruction counters of the pass-wait monitor.
- Watches those counters and the core's gp (x3) value, and detects end of test, timeout or fetch hang.
- After a settle window it issues a single sticky verdict: pass, fail, timeout or hang.
- Latches the cycle and instruction statistics at test end for the bench's report/CPI printout.

Parameters:
- XLEN, 64, width of gp_value (matches core XLEN).
- TIMEOUT_CYCLES, 32'd2000000, cycle_count threshold for timeout verdict.
- HANG_CYCLES, 32'd10000, consecutive cycles without valid_ir_cycle change that constitute a hang.
- SETTLE_CYCLES, 8'd16, cycles waited after tohost detection before sampling gp_value.
- MIN_TOHOST_CNT, 32'd1, pc_write_to_host_cnt value that marks end of test.

Ports:
- tb_clk  input  1  testbench clock.
- tb_rst_n  input  1  asynchronous active-low reset.
- pc_write_to_host_cnt  input  32  number of committed tohost writes.
- pc_write_to_host_cycle  input  32  cycle of first tohost write.
- valid_ir_cycle  input  32  fetch-handshake count, frozen after first tohost write.
- cycle_count  input  32  free-running cycle counter.
- gp_value  input  XLEN  architectural x3; value 1 means pass.
- sim_done  output  1  sticky; verdict valid.
- sim_done_pulse  output  1  one-cycle pulse on entering DONE.
- sim_pass  output  1  sticky pass flag.
- sim_fail  output  1  sticky fail flag (gp != 1).
- sim_timeout  output  1  sticky timeout flag.
- sim_hang  output  1  sticky hang flag.
- result_cycles  output  32  latched pc_write_to_host_cycle, or cycle_count on timeout/hang.
- result_instrs  output  32  latched valid_ir_cycle.

Behaviour:
- Reset: all outputs 0, state RUN, hang_cnt 0, settle_cnt 0, prev_ir 0. Reset is asynchronous and active-low; asserting it at any point, including mid-SETTLE or in DONE, returns to this state immediately.
- States: RUN, SETTLE, CHECK, DONE. Exactly one transition per clock.
- RUN:
  - prev_ir <= valid_ir_cycle each cycle.
  - hang_cnt <= 0 if valid_ir_cycle != prev_ir, else hang_cnt+1, saturating at HANG_CYCLES.
  - Exit priority, evaluated every cycle:
    1. pc_write_to_host_cnt >= MIN_TOHOST_CNT -> SETTLE; latch result_cycles = pc_write_to_host_cycle and result_instrs = valid_ir_cycle.
    2. Else cycle_count >= TIMEOUT_CYCLES -> DONE with sim_timeout=1; latch result_cycles = cycle_count and result_instrs = valid_ir_cycle.
    3. Else hang_cnt == HANG_CYCLES -> DONE with sim_hang=1; same latching as timeout.
  - Tohost detection and timeout in the same cycle -> tohost wins.
- SETTLE:
  - settle_cnt counts from 0. Leave for CHECK on the cycle settle_cnt == SETTLE_CYCLES-1, i.e. exactly SETTLE_CYCLES cycles spent in SETTLE.
  - Timeout and hang are not evaluated. Further tohost writes are ignored.
  - SETTLE_CYCLES==0 is treated as 1.
- CHECK: one cycle. Sample gp_value: ==1 sets sim_pass, otherwise sim_fail. -> DONE.
- DONE:
  - Absorbing until reset. sim_done=1.
  - Exactly one of sim_pass/sim_fail/sim_timeout/sim_hang is 1.
  - result_* frozen.
- sim_done_pulse is high only in the first DONE cycle. All flags change in the same cycle as sim_done rises.
- Latency: tohost detection in RUN at cycle T -> SETTLE at T+1 -> CHECK at T+1+SETTLE_CYCLES -> sim_done at T+2+SETTLE_CYCLES.
- Compares are unsigned 32-bit. The hang counter is 32-bit and saturates, never wraps.
- Inputs are sampled only on tb_clk rising edge. No combinational input-to-output paths.

Test Plan:
- Pass: cnt rises 0->1 at cycle 500 with pc_write_to_host_cycle=480, valid_ir_cycle=300, gp=1 -> sim_done at cycle 518 (SETTLE_CYCLES=16); sim_pass=1, result_cycles=480, result_instrs=300, one-cycle sim_done_pulse.
- Fail: same as pass, but gp=3 during CHECK (gp=1 before) -> sim_fail=1, sim_pass=0; verifies gp is sampled only in CHECK.
- Timeout: TIMEOUT_CYCLES=1000, cnt stays 0, valid_ir_cycle keeps incrementing -> sim_timeout=1 one cycle after cycle_count reaches 1000; result_cycles=1000.
- Hang: HANG_CYCLES=50, valid_ir_cycle freezes at 77 -> sim_hang=1 after 50 unchanged cycles; result_instrs=77. A single change at cycle 40 restarts the count.
- Priority: cnt becomes 1 in the same cycle cycle_count reaches TIMEOUT_CYCLES -> goes to SETTLE, final verdict pass/fail, sim_timeout stays 0.
- Reset mid-SETTLE: tb_rst_n low for 2 cycles during SETTLE -> all outputs 0 immediately; after release, a full RUN->DONE sequence repeats correctly.

Source files
------------

// File: rtl/tb_sim_verdict.sv
// End-of-test judge: watches the tohost/cycle/instruction counters and gp, then issues
// one sticky verdict (pass, fail, timeout or hang) and freezes the run statistics.
module tb_sim_verdict #(
  parameter int unsigned XLEN           = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
  parameter logic [31:0] HANG_CYCLES    = 32'd10000,
  parameter logic [7:0]  SETTLE_CYCLES  = 8'd16,
  parameter logic [31:0] MIN_TOHOST_CNT = 32'd1
) (
  input  logic            tb_clk,
  input  logic            tb_rst_n,
  input  logic [31:0]     pc_write_to_host_cnt,
  input  logic [31:0]     pc_write_to_host_cycle,
  input  logic [31:0]     valid_ir_cycle,
  input  logic [31:0]     cycle_count,
  input  logic [XLEN-1:0] gp_value,
  output logic            sim_done,
  output logic            sim_done_pulse,
  output logic            sim_pass,
  output logic            sim_fail,
  output logic            sim_timeout,
  output logic            sim_hang,
  output logic [31:0]     result_cycles,
  output logic [31:0]     result_instrs
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // A zero-length settle window behaves like a one-cycle window.
  localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 8'd0) ? 8'd0 : SETTLE_CYCLES - 8'd1;
  localparam logic [XLEN-1:0] GP_PASS = XLEN'(1);

  logic [1:0]  state;
  logic [7:0]  settle_cnt;
  logic [31:0] hang_cnt;
  logic [31:0] prev_ir;

  // Stall counter saturates at the hang threshold so it can never wrap back below it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v >= HANG_CYCLES) ? HANG_CYCLES : v + 32'd1;
  endfunction

  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      state          <= ST_RUN;
      settle_cnt     <= 8'd0;
      hang_cnt       <= 32'd0;
      prev_ir        <= 32'd0;
      sim_done       <= 1'b0;
      sim_done_pulse <= 1'b0;
      sim_pass       <= 1'b0;
      sim_fail       <= 1'b0;
      sim_timeout    <= 1'b0;
      sim_hang       <= 1'b0;
      result_cycles  <= 32'd0;
      result_instrs  <= 32'd0;
    end else begin
      sim_done_pulse <= 1'b0;
      case (state)
        ST_RUN: begin
          prev_ir  <= valid_ir_cycle;
          hang_cnt <= (valid_ir_cycle != prev_ir) ? 32'd0 : sat_inc(hang_cnt);
          // Tohost beats timeout, timeout beats hang.
          if (pc_write_to_host_cnt >= MIN_TOHOST_CNT) begin
            state         <= ST_SETTLE;
            settle_cnt    <= 8'd0;
            result_cycles <= pc_write_to_host_cycle;
            result_instrs <= valid_ir_cycle;
          end else if (cycle_count >= TIMEOUT_CYCLES) begin
            state          <= ST_DONE;
            sim_done       <= 1'b1;
            sim_done_pulse <= 1'b1;
            sim_timeout    <= 1'b1;
            result_cycles  <= cycle_count;
            result_instrs  <= valid_ir_cycle;
          end else if (hang_cnt == HANG_CYCLES) begin
            state          <= ST_DONE;
            sim_done       <= 1'b1;
            sim_done_pulse <= 1'b1;
            sim_hang       <= 1'b1;
            result_cycles  <= cycle_count;
            result_instrs  <= valid_ir_cycle;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_CHECK: begin
          state          <= ST_DONE;
          sim_done       <= 1'b1;
          sim_done_pulse <= 1'b1;
          if (gp_value == GP_PASS) begin
            sim_pass <= 1'b1;
          end else begin
            sim_fail <= 1'b1;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_sim_verdict.sv
// Randomized bench for tb_sim_verdict: a rule-level model queues each expected verdict
// and a negedge monitor compares it whenever the DUT pulses sim_done_pulse.
module tb_tb_sim_verdict;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] TO_C = 32'd1000;
  localparam logic [31:0] HANG_C = 32'd50;
  localparam int          SETTLE_C = 16;
  localparam logic [31:0] MIN_C = 32'd1;

  logic            tb_clk = 1'b0;
  logic            tb_rst_n = 1'b1;
  logic [31:0]     pc_write_to_host_cnt = '0;
  logic [31:0]     pc_write_to_host_cycle = '0;
  logic [31:0]     valid_ir_cycle = '0;
  logic [31:0]     cycle_count = '0;
  logic [XLEN-1:0] gp_value = '0;
  logic            sim_done, sim_done_pulse, sim_pass, sim_fail, sim_timeout, sim_hang;
  logic [31:0]     result_cycles, result_instrs;

  tb_sim_verdict #(
    .XLEN(XLEN), .TIMEOUT_CYCLES(TO_C), .HANG_CYCLES(HANG_C),
    .SETTLE_CYCLES(8'(SETTLE_C)), .MIN_TOHOST_CNT(MIN_C)
  ) dut (
    .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
    .pc_write_to_host_cnt(pc_write_to_host_cnt),
    .pc_write_to_host_cycle(pc_write_to_host_cycle),
    .valid_ir_cycle(valid_ir_cycle), .cycle_count(cycle_count), .gp_value(gp_value),
    .sim_done(sim_done), .sim_done_pulse(sim_done_pulse), .sim_pass(sim_pass),
    .sim_fail(sim_fail), .sim_timeout(sim_timeout), .sim_hang(sim_hang),
    .result_cycles(result_cycles), .result_instrs(result_instrs)
  );

  always #5 tb_clk = ~tb_clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  always @(posedge tb_clk) edge_cnt <= edge_cnt + 1;

  // flags = {pass, fail, timeout, hang}
  typedef struct {
    int          edge_n;
    logic [3:0]  flags;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: phase 0 = still running, 1 = tohost seen and waiting for the gp sample, 2 = verdict given.
  int          m_phase, m_edge, m_check, m_streak;
  logic [31:0] m_prev, m_lc, m_li;

  function automatic void model_reset();
    m_phase = 0; m_edge = 0; m_check = 0; m_streak = 0;
    m_prev = '0; m_lc = '0; m_li = '0;
  endfunction

  function automatic bit check_next();
    return (m_phase == 1) && (m_edge + 1 == m_check);
  endfunction

  function automatic void push_exp(input logic [3:0] f, input logic [31:0] c, input logic [31:0] n);
    exp_t e;
    e.edge_n = edge_cnt + 1; e.flags = f; e.cyc = c; e.ins = n;
    sb.push_back(e);
  endfunction

  // Called with the inputs that the DUT will sample at the next rising edge.
  function automatic void model_edge();
    m_edge++;
    if (m_phase == 0) begin
      if (pc_write_to_host_cnt >= MIN_C) begin
        m_phase = 1; m_lc = pc_write_to_host_cycle; m_li = valid_ir_cycle;
        m_check = m_edge + SETTLE_C + 1;
      end else if (cycle_count >= TO_C) begin
        m_phase = 2; push_exp(4'b0010, cycle_count, valid_ir_cycle);
      end else if (m_streak >= int'(HANG_C)) begin
        m_phase = 2; push_exp(4'b0001, cycle_count, valid_ir_cycle);
      end
      if (valid_ir_cycle != m_prev) m_streak = 0;
      else if (m_streak < int'(HANG_C)) m_streak++;
      m_prev = valid_ir_cycle;
    end else if (m_phase == 1 && m_edge == m_check) begin
      m_phase = 2;
      push_exp((gp_value == 64'd1) ? 4'b1000 : 4'b0100, m_lc, m_li);
    end
  endfunction

  // Monitor: compares whenever a verdict is presented.
  logic last_pulse = 1'b0;
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge tb_clk) begin
    if (!tb_rst_n) begin
      last_pulse = 1'b0; prev_done = 1'b0;
    end else begin
      if (last_pulse) begin
        chk32("pulse_width", 32'(sim_done_pulse), 32'd0);
        chk32("done_sticky", 32'(sim_done), 32'd1);
      end
      if (sim_done && !prev_done && !sim_done_pulse) begin
        checks++; errors++;
        $display("FAIL done_without_pulse: sim_done rose with sim_done_pulse=0 at t=%0t", $time);
      end
      if (sim_done_pulse) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: verdict flags=%b with nothing expected at t=%0t",
                   {sim_pass, sim_fail, sim_timeout, sim_hang}, $time);
        end else begin
          mon_e = sb.pop_front();
          chk32("done_edge", 32'(edge_cnt), 32'(mon_e.edge_n));
          chk32("verdict_flags", {28'd0, sim_pass, sim_fail, sim_timeout, sim_hang}, {28'd0, mon_e.flags});
          chk32("done_flag", 32'(sim_done), 32'd1);
          chk32("result_cycles", result_cycles, mon_e.cyc);
          chk32("result_instrs", result_instrs, mon_e.ins);
        end
      end
      last_pulse = sim_done_pulse;
      prev_done = sim_done;
    end
  end

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge tb_clk);
    tb_rst_n = 1'b0;
    #1;
    chk32("rst_flags", {26'd0, sim_done, sim_done_pulse, sim_pass, sim_fail, sim_timeout, sim_hang}, 32'd0);
    chk32("rst_cycles", result_cycles, 32'd0);
    chk32("rst_instrs", result_instrs, 32'd0);
    sb.delete();
    model_reset();
    pc_write_to_host_cnt = '0; pc_write_to_host_cycle = '0;
    valid_ir_cycle = '0; cycle_count = '0; gp_value = '0;
    repeat (2) @(negedge tb_clk);
    tb_rst_n = 1'b1;
  endtask

  // kind: 0 pass, 1 fail, 2 timeout, 3 hang, 4 tohost/timeout tie, 5 random, 6 reset mid-settle
  task automatic run_case(input int kind, input int max_cyc);
    int rt, base, frz;
    logic [63:0] fgp;
    do_reset();
    rt = $urandom_range(20, 700);
    base = $urandom_range(0, 900);
    frz = 0;
    fgp = ($urandom_range(0, 1) == 1) ? 64'd1 : {$urandom, $urandom} | 64'd2;
    for (int i = 0; i < max_cyc; i++) begin
      if (kind == 6 && i == 38) begin
        do_reset();
        break;
      end
      gp_value = 64'd1;
      case (kind)
        0, 1: begin
          cycle_count = 32'(i); pc_write_to_host_cnt = (i >= 500) ? 32'd1 : 32'd0;
          pc_write_to_host_cycle = 32'd480; valid_ir_cycle = (i < 500) ? 32'(i * 3 / 5) : 32'd300;
        end
        2: begin
          cycle_count = 32'(900 + i); pc_write_to_host_cnt = '0; valid_ir_cycle = 32'(i);
        end
        3: begin
          cycle_count = 32'(i); pc_write_to_host_cnt = '0; valid_ir_cycle = (i < 40) ? 32'd76 : 32'd77;
        end
        4: begin
          cycle_count = 32'(990 + i); pc_write_to_host_cnt = (cycle_count >= TO_C) ? 32'd1 : 32'd0;
          pc_write_to_host_cycle = 32'd995; valid_ir_cycle = 32'(i);
        end
        5: begin
          cycle_count = 32'(base + i);
          pc_write_to_host_cycle = 32'(rt);
          if (i >= rt) begin
            if (pc_write_to_host_cnt == 0) pc_write_to_host_cnt = 32'd1;
            else if ($urandom_range(0, 7) == 0) pc_write_to_host_cnt = pc_write_to_host_cnt + 32'd1;
          end else if (frz > 0) begin
            frz--;
          end else if ($urandom_range(0, 99) == 0) begin
            frz = $urandom_range(40, 60);
          end else if ($urandom_range(0, 3) != 0) begin
            valid_ir_cycle = valid_ir_cycle + 32'd1;
          end
          gp_value = ($urandom_range(0, 1) == 1) ? 64'd1 : {$urandom, $urandom};
        end
        default: begin
          cycle_count = 32'(i); pc_write_to_host_cnt = (i >= 30) ? 32'd1 : 32'd0;
          pc_write_to_host_cycle = 32'd25; valid_ir_cycle = (i < 30) ? 32'(i) : 32'd30;
        end
      endcase
      if (check_next()) begin
        if (kind == 1) gp_value = 64'd3;
        else if (kind == 4) gp_value = fgp;
      end
      model_edge();
      @(negedge tb_clk);
    end
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge tb_clk);
    #1;
    chk32("verdict_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    model_reset();
    run_case(0, 540);
    run_case(1, 540);
    run_case(2, 130);
    run_case(3, 150);
    run_case(4, 40);
    run_case(6, 60);
    run_case(0, 540);
    for (int r = 0; r < 6; r++) run_case(5, 1100);
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
